// File: rtl/div_restoring.sv
// Sequential unsigned restoring divider: one quotient bit per clock, DW iterations,
// then a one-cycle vld_out pulse with q/r/dz held until the next result.
module div_restoring #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld_in,
    input  logic [DW-1:0] x,
    input  logic [VW-1:0] y,
    output logic          busy,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          dz,
    output logic          vld_out
);

    localparam int CW = $clog2(DW) + 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [VW:0]   rem_p;
    logic [DW-1:0] sh_p;
    logic [VW-1:0] den_p;

    logic [VW+1:0] step;
    logic [VW:0]   rem_nxt;
    logic [DW-1:0] sh_nxt;

    // Trial subtract on the shifted partial remainder; the borrow bit selects restore.
    // Returns {next partial remainder, quotient bit}.
    function automatic logic [VW+1:0] restore_step(input logic [VW+1:0] part,
                                                   input logic [VW-1:0] d);
        logic [VW+1:0] diff;
        diff = part - {2'b00, d};
        if (diff[VW+1])
            return {part[VW:0], 1'b0};
        return {diff[VW:0], 1'b1};
    endfunction

    assign step    = restore_step({rem_p, sh_p[DW-1]}, den_p);
    assign rem_nxt = step[VW+1:1];
    assign sh_nxt  = {sh_p[DW-2:0], step[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            q       <= '0;
            r       <= '0;
            dz      <= 1'b0;
            vld_out <= 1'b0;
        end else begin
            vld_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (vld_in) begin
                        den_p <= y;
                        sh_p  <= x;
                        rem_p <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem_p <= rem_nxt;
                    sh_p  <= sh_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(DW - 1)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        vld_out <= 1'b1;
                        // A zero divisor runs the full latency but reports a fixed result.
                        if (den_p == '0) begin
                            q  <= '1;
                            r  <= '0;
                            dz <= 1'b1;
                        end else begin
                            q  <= sh_nxt;
                            r  <= rem_nxt[VW-1:0];
                            dz <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/div_restoring.md
Name: div_restoring

Overview:
- Sequential unsigned restoring divider: the inverse operation to the team's add-tree multiplier.
- Accepts a DW-bit dividend and a VW-bit divisor under a single-cycle valid strobe.
- Produces quotient and remainder one bit per clock, then raises a one-cycle result-valid pulse.
- Used to undo or check multiplier products in the arithmetic datapath; shares its vld_in/vld_out handshake style.

Parameters:
DW, 8, dividend and quotient width
VW, 4, divisor and remainder width (VW <= DW)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
vld_in  input  1  request strobe; operands sampled when high and busy low
x  input  DW  dividend (unsigned)
y  input  VW  divisor (unsigned)
busy  output  1  high while a division is in progress
q  output  DW  quotient, held until next result
r  output  VW  remainder, held until next result
dz  output  1  divide-by-zero flag for the current q/r
vld_out  output  1  one-cycle pulse when q/r/dz are updated

Behaviour:
- Reset: one clock, synchronous, active-high; rst sampled high at a rising edge wins over every other event.
  - Values after that edge: busy=0, q=0, r=0, dz=0, vld_out=0, FSM=IDLE, iteration counter=0.
  - Reset mid-operation aborts the division; no vld_out follows.
- FSM: IDLE -> CALC -> IDLE.
  - IDLE: vld_in=1 at edge N -> capture x, y; clear the partial remainder (VW+1 bits); load the shift register with x; counter=0; go to CALC; busy=1 after edge N.
  - CALC: one restoring iteration per edge.
    - Shift {partial remainder, dividend} left 1.
    - Trial-subtract y from the partial remainder.
    - If no borrow, keep the difference and shift in quotient bit 1; else restore and shift in 0.
    - Counter increments each iteration.
  - The DW-th iteration occurs at edge N+DW. At that edge:
    - q, r, dz are registered from the final values.
    - vld_out=1 for the following cycle only; busy=0; FSM returns to IDLE.
- Latency: vld_out high exactly DW cycles after the accepting edge (8 cycles at defaults). Throughput is one division per DW cycles.
- vld_in while busy=1 is ignored. Operands are not queued, and no error is raised.
- Back-to-back: vld_in may be high in the cycle vld_out is high (FSM already IDLE); it is accepted at that edge.
- x, y are only sampled at the accepting edge. Changes afterwards have no effect on the result.
- Divide by zero (y=0 at accept): same latency; result forced to q=all ones, r=0, dz=1.
- dz=0 for every nonzero divisor. dz, q, r keep their values until the next vld_out or reset.
- Arithmetic:
  - q = floor(x/y), r = x mod y.
  - r always < y, and x = q*y + r exactly.
  - The partial remainder is VW+1 bits wide so the trial subtract never overflows.
- vld_out is never high for two consecutive cycles.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then release -> busy=0, q=0, r=0, dz=0, vld_out=0; no vld_out over 20 idle cycles.
- Basic, with dividend taken from the multiplier's 13*6 product: x=78, y=6, vld_in one cycle -> busy for 8 cycles; vld_out single pulse 8 cycles after accept; q=13, r=0, dz=0.
- Boundary values, each divide waiting for vld_out:
  - x=200, y=7 -> q=28, r=4
  - x=255, y=1 -> q=255, r=0
  - x=5, y=9 -> q=0, r=5
  - x=0, y=15 -> q=0, r=0
  - x=255, y=15 -> q=17, r=0
- Divide by zero: x=100, y=0 -> q=255, r=0, dz=1 after 8 cycles. Then x=100, y=10 -> q=10, r=0, dz=0.
- Busy collision and back-to-back:
  - Issue x=200, y=7; pulse vld_in with x=9, y=3 at cycles 3 and 5 after accept -> ignored; result q=28, r=4.
  - Assert x=9, y=3 in the vld_out cycle -> accepted; q=3, r=0 after 8 more cycles.
- Reset mid-operation: issue x=78, y=6; assert rst 4 cycles after accept -> no vld_out; outputs return to reset values; a new x=50, y=8 afterwards -> q=6, r=2.
